// File: rtl/park_occupancy_if.sv
// Bus bundle for the parking-lot occupancy tracker: entry/exit requests in,
// occupancy status, grant/deny pulses and gate drive out.
interface park_occupancy_if;
  logic       enter;
  logic       exit_valid;
  logic [7:0] park_location;
  logic [7:0] occupancy;
  logic [3:0] free_count;
  logic       full;
  logic       empty;
  logic       enter_grant;
  logic [2:0] assigned_space;
  logic       enter_deny;
  logic       gate_open;
  logic       exit_err;

  modport master (
    output enter, exit_valid, park_location,
    input  occupancy, free_count, full, empty, enter_grant,
           assigned_space, enter_deny, gate_open, exit_err
  );

  modport slave (
    input  enter, exit_valid, park_location,
    output occupancy, free_count, full, empty, enter_grant,
           assigned_space, enter_deny, gate_open, exit_err
  );
endinterface

// File: rtl/park_occupancy.sv
// Eight-space parking lot tracker: lowest-free allocation, timed entry gate,
// one-hot exits. Define PARK_ERR_EN to compile in malformed-exit reporting.
module park_occupancy #(
  parameter int unsigned GATE_CYCLES = 8
) (
  input logic            clk,
  input logic            rst_n,
  park_occupancy_if.slave bus
);

  typedef enum logic {IDLE, GATE} state_t;

  localparam logic [7:0] GATE_TC = 8'(GATE_CYCLES);

  state_t     state_q;
  logic [7:0] occ_q;
  logic [3:0] free_q;
  logic       full_q;
  logic       empty_q;
  logic       grant_q;
  logic       deny_q;
  logic [2:0] space_q;
  logic       gate_q;
  logic [7:0] cnt_q;

  logic       exit_hit;
  logic [7:0] exit_mask;
  logic       do_grant;
  logic       do_deny;
  logic [2:0] grant_idx;
  logic [7:0] grant_mask;
  logic [7:0] occ_next;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] lowest_free(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // Allocation looks at pre-exit occupancy so a space vacated this cycle
  // cannot be handed out in the same cycle.
  always_comb begin
    exit_hit   = bus.exit_valid && is_onehot(bus.park_location)
                 && ((bus.park_location & occ_q) != 8'd0);
    exit_mask  = exit_hit ? bus.park_location : 8'd0;
    do_grant   = (state_q == IDLE) && bus.enter && !full_q;
    do_deny    = (state_q == IDLE) && bus.enter && full_q;
    grant_idx  = lowest_free(occ_q);
    grant_mask = do_grant ? (8'd1 << grant_idx) : 8'd0;
    occ_next   = (occ_q & ~exit_mask) | grant_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      occ_q   <= 8'd0;
      free_q  <= 4'd8;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      grant_q <= 1'b0;
      deny_q  <= 1'b0;
      space_q <= 3'd0;
      gate_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      occ_q   <= occ_next;
      free_q  <= 4'd8 - popcount(occ_next);
      full_q  <= &occ_next;
      empty_q <= ~|occ_next;
      grant_q <= do_grant;
      deny_q  <= do_deny;
      if (do_grant) space_q <= grant_idx;
      case (state_q)
        IDLE: begin
          if (do_grant) begin
            state_q <= GATE;
            gate_q  <= 1'b1;
            cnt_q   <= 8'd1;
          end
        end
        GATE: begin
          // The grant cycle is gate cycle 1; leave once the terminal count is shown.
          if (cnt_q == GATE_TC) begin
            state_q <= IDLE;
            gate_q  <= 1'b0;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          gate_q  <= 1'b0;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

`ifdef PARK_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= bus.exit_valid && !exit_hit;
  end

  assign bus.exit_err = err_q;
`else
  assign bus.exit_err = 1'b0;
`endif

  assign bus.occupancy      = occ_q;
  assign bus.free_count     = free_q;
  assign bus.full           = full_q;
  assign bus.empty          = empty_q;
  assign bus.enter_grant    = grant_q;
  assign bus.assigned_space = space_q;
  assign bus.enter_deny     = deny_q;
  assign bus.gate_open      = gate_q;

endmodule

// File: tb/tb_park_occupancy.sv
// Directed bench for park_occupancy: one instance with GATE_CYCLES=2 for the
// allocation/exit scenarios and one with GATE_CYCLES=8 for mid-gate reset.
module tb_park_occupancy;

  logic clk = 1'b0;
  logic rst2_n;
  logic rst8_n;

  park_occupancy_if bus2();
  park_occupancy_if bus8();

  park_occupancy #(.GATE_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));
  park_occupancy #(.GATE_CYCLES(8)) u_dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PARK_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant2(output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!bus2.enter_grant && cyc < 10);
    if (!bus2.enter_grant) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_exit2(input logic v, input logic [7:0] loc);
    bus2.exit_valid    = v;
    bus2.park_location = loc;
  endtask

  initial begin
    int         cyc;
    logic [7:0] exp_occ;

    rst2_n = 1'b0;
    rst8_n = 1'b0;
    bus2.enter = 1'b0;
    drive_exit2(1'b0, 8'd0);
    bus8.enter = 1'b0;
    bus8.exit_valid = 1'b0;
    bus8.park_location = 8'd0;
    step();
    step();

    // Reset state
    chk("rst_occ",   32'(bus2.occupancy), 32'h00);
    chk("rst_free",  32'(bus2.free_count), 32'd8);
    chk("rst_empty", 32'(bus2.empty), 32'd1);
    chk("rst_full",  32'(bus2.full), 32'd0);
    chk("rst_gate",  32'(bus2.gate_open), 32'd0);
    chk("rst_grant", 32'(bus2.enter_grant), 32'd0);
    chk("rst_deny",  32'(bus2.enter_deny), 32'd0);
    chk("rst_space", 32'(bus2.assigned_space), 32'd0);
    chk("rst_err",   32'(bus2.exit_err), 32'd0);
    rst2_n = 1'b1;

    // Eight grants with enter held: first on the first edge, then every 3 cycles
    bus2.enter = 1'b1;
    exp_occ = 8'h00;
    for (int g = 0; g < 8; g++) begin
      wait_grant2(cyc);
      exp_occ = exp_occ | (8'd1 << g);
      chk("fill_gap",   32'(cyc), (g == 0) ? 32'd1 : 32'd3);
      chk("fill_space", 32'(bus2.assigned_space), 32'(g));
      chk("fill_occ",   32'(bus2.occupancy), 32'(exp_occ));
      chk("fill_gate",  32'(bus2.gate_open), 32'd1);
      if (g == 0) chk("fill_empty0", 32'(bus2.empty), 32'd0);
    end
    bus2.enter = 1'b0;
    chk("full_flag", 32'(bus2.full), 32'd1);
    chk("full_free", 32'(bus2.free_count), 32'd0);
    step();
    chk("gate_c2", 32'(bus2.gate_open), 32'd1);
    step();
    chk("gate_c3", 32'(bus2.gate_open), 32'd0);

    // Full lot: deny every IDLE cycle while enter is held
    bus2.enter = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("deny_pulse", 32'(bus2.enter_deny), 32'd1);
      chk("deny_occ",   32'(bus2.occupancy), 32'hFF);
      chk("deny_gate",  32'(bus2.gate_open), 32'd0);
    end

    // Deny plus simultaneous exit of space 7, then space 7 is regranted
    drive_exit2(1'b1, 8'h80);
    step();
    chk("dx_deny", 32'(bus2.enter_deny), 32'd1);
    chk("dx_occ",  32'(bus2.occupancy), 32'h7F);
    chk("dx_free", 32'(bus2.free_count), 32'd1);
    chk("dx_full", 32'(bus2.full), 32'd0);
    drive_exit2(1'b0, 8'd0);
    step();
    chk("dx_grant", 32'(bus2.enter_grant), 32'd1);
    chk("dx_space", 32'(bus2.assigned_space), 32'd7);
    chk("dx_occ2",  32'(bus2.occupancy), 32'hFF);
    bus2.enter = 1'b0;

    // Drain down to 0x0F with exits while the gate is still timing out
    drive_exit2(1'b1, 8'h80); step();
    drive_exit2(1'b1, 8'h40); step();
    drive_exit2(1'b1, 8'h20); step();
    drive_exit2(1'b1, 8'h10); step();
    chk("drain_occ", 32'(bus2.occupancy), 32'h0F);
    chk("drain_gate", 32'(bus2.gate_open), 32'd0);
    drive_exit2(1'b1, 8'h02); step();
    chk("ex2_occ",  32'(bus2.occupancy), 32'h0D);
    chk("ex2_free", 32'(bus2.free_count), 32'd5);
    drive_exit2(1'b0, 8'd0);
    bus2.enter = 1'b1;
    step();
    chk("ex2_grant", 32'(bus2.enter_grant), 32'd1);
    chk("ex2_space", 32'(bus2.assigned_space), 32'd1);
    chk("ex2_occ2",  32'(bus2.occupancy), 32'h0F);
    bus2.enter = 1'b0;
    step();
    chk("grant_once", 32'(bus2.enter_grant), 32'd0);
    step();

    // Grant and exit together: allocation ignores the space freed this cycle
    bus2.enter = 1'b1;
    drive_exit2(1'b1, 8'h01);
    step();
    chk("sim_grant", 32'(bus2.enter_grant), 32'd1);
    chk("sim_space", 32'(bus2.assigned_space), 32'd4);
    chk("sim_occ",   32'(bus2.occupancy), 32'h1E);
    bus2.enter = 1'b0;
    drive_exit2(1'b0, 8'd0);
    step();
    chk("space_hold", 32'(bus2.assigned_space), 32'd4);
    step();

    // Malformed or unoccupied exits leave occupancy alone
    drive_exit2(1'b1, 8'h03); step();
    chk("bad_multi_occ", 32'(bus2.occupancy), 32'h1E);
    chk("bad_multi_err", 32'(bus2.exit_err), 32'(ERR_EXP));
    drive_exit2(1'b1, 8'h00); step();
    chk("bad_zero_occ", 32'(bus2.occupancy), 32'h1E);
    chk("bad_zero_err", 32'(bus2.exit_err), 32'(ERR_EXP));
    drive_exit2(1'b1, 8'h80); step();
    chk("bad_free_occ", 32'(bus2.occupancy), 32'h1E);
    chk("bad_free_err", 32'(bus2.exit_err), 32'(ERR_EXP));
    drive_exit2(1'b1, 8'h04); step();
    chk("good_occ", 32'(bus2.occupancy), 32'h1A);
    chk("good_err", 32'(bus2.exit_err), 32'd0);
    drive_exit2(1'b0, 8'd0); step();
    chk("idle_err", 32'(bus2.exit_err), 32'd0);

    // Empty lot: exits 0x03 then 0x10
    rst2_n = 1'b0;
    #1;
    chk("rerst_occ", 32'(bus2.occupancy), 32'h00);
    step();
    rst2_n = 1'b1;
    drive_exit2(1'b1, 8'h03); step();
    chk("emp_err1", 32'(bus2.exit_err), 32'(ERR_EXP));
    chk("emp_occ1", 32'(bus2.occupancy), 32'h00);
    drive_exit2(1'b1, 8'h10); step();
    chk("emp_err2", 32'(bus2.exit_err), 32'(ERR_EXP));
    chk("emp_occ2", 32'(bus2.occupancy), 32'h00);
    drive_exit2(1'b0, 8'd0); step();
    chk("emp_err3", 32'(bus2.exit_err), 32'd0);
    chk("emp_empty", 32'(bus2.empty), 32'd1);

    // GATE_CYCLES=8: reset during the 4th gate cycle
    rst8_n = 1'b1;
    bus8.enter = 1'b1;
    step();
    chk("g8_grant", 32'(bus8.enter_grant), 32'd1);
    chk("g8_space", 32'(bus8.assigned_space), 32'd0);
    bus8.enter = 1'b0;
    step();
    step();
    step();
    chk("g8_gate4", 32'(bus8.gate_open), 32'd1);
    chk("g8_occ4",  32'(bus8.occupancy), 32'h01);
    #2;
    rst8_n = 1'b0;
    #1;
    chk("g8_rst_gate",  32'(bus8.gate_open), 32'd0);
    chk("g8_rst_occ",   32'(bus8.occupancy), 32'h00);
    chk("g8_rst_free",  32'(bus8.free_count), 32'd8);
    chk("g8_rst_empty", 32'(bus8.empty), 32'd1);
    step();
    rst8_n = 1'b1;
    bus8.enter = 1'b1;
    step();
    chk("g8_re_grant", 32'(bus8.enter_grant), 32'd1);
    chk("g8_re_space", 32'(bus8.assigned_space), 32'd0);
    chk("g8_re_occ",   32'(bus8.occupancy), 32'h01);
    bus8.enter = 1'b0;
    // Gate stays open for all 8 cycles, closed on the 9th
    for (int k = 2; k <= 8; k++) begin
      step();
      chk("g8_gate_hold", 32'(bus8.gate_open), 32'd1);
    end
    step();
    chk("g8_gate_close", 32'(bus8.gate_open), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
